// File: rtl/adc_iq_sampler.sv
// ADC I/Q front end: offset-binary to two's complement, decimation by DECIM,
// and a DEPTH-entry show-ahead FIFO feeding the demodulator on a valid/ready stream.
module adc_iq_sampler #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int DECIM  = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     valid_ADC,
  output logic                     ready_ADC,
  input  logic [DATA_W-1:0]        adc_i,
  input  logic [DATA_W-1:0]        adc_q,
  output logic                     iq_valid,
  input  logic                     iq_ready,
  output logic [DATA_W-1:0]        iq_i,
  output logic [DATA_W-1:0]        iq_q,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DATA_W-1:0] mem_i [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PH_W-1:0]   phase;
  logic              accept;
  logic              push;
  logic              pop;
  logic [FILL_W-1:0] fill_next;

  always_comb begin
    accept    = valid_ADC & ready_ADC;
    push      = accept & (phase == '0);
    pop       = iq_valid & iq_ready;
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + 1'b1;
    end else if (pop && !push) begin
      fill_next = fill - 1'b1;
    end
  end

  // ready_ADC looks only at the registered fill, so a pop at full frees a slot one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      phase     <= '0;
      fill      <= '0;
      iq_valid  <= 1'b0;
      ready_ADC <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept) begin
        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
      fill      <= fill_next;
      iq_valid  <= (fill_next != '0);
      ready_ADC <= (fill_next < FILL_W'(DEPTH));
      if (valid_ADC && !ready_ADC) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Storage is cleared on reset so the show-ahead outputs read 0 while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_i[k] <= '0;
        mem_q[k] <= '0;
      end
    end else if (push) begin
      mem_i[wr_ptr] <= {~adc_i[DATA_W-1], adc_i[DATA_W-2:0]};
      mem_q[wr_ptr] <= {~adc_q[DATA_W-1], adc_q[DATA_W-2:0]};
    end
  end

  assign iq_i = mem_i[rd_ptr];
  assign iq_q = mem_q[rd_ptr];

endmodule

// File: tb/tb_adc_iq_sampler.sv
// Scoreboard bench for adc_iq_sampler: a DECIM=2 and a DECIM=1 instance share the
// stimulus; a queue-based model predicts samples and flags, a negedge monitor compares.
module tb_adc_iq_sampler;
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int FW    = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic valid_adc = 1'b0;
  logic iq_ready = 1'b0;
  logic ovr_clr = 1'b0;
  logic [DW-1:0] adc_i = '0;
  logic [DW-1:0] adc_q = '0;
  logic [1:0] rdy, vld, ovr;
  logic [1:0][DW-1:0] oi, oq;
  logic [1:0][FW-1:0] fl;

  always #5 clk = ~clk;

  adc_iq_sampler #(.DATA_W(DW), .DEPTH(DEPTH), .DECIM(2)) u_dec2 (
    .clk(clk), .resetn(resetn), .valid_ADC(valid_adc), .ready_ADC(rdy[0]),
    .adc_i(adc_i), .adc_q(adc_q), .iq_valid(vld[0]), .iq_ready(iq_ready),
    .iq_i(oi[0]), .iq_q(oq[0]), .fill(fl[0]), .overrun(ovr[0]), .ovr_clr(ovr_clr));

  adc_iq_sampler #(.DATA_W(DW), .DEPTH(DEPTH), .DECIM(1)) u_dec1 (
    .clk(clk), .resetn(resetn), .valid_ADC(valid_adc), .ready_ADC(rdy[1]),
    .adc_i(adc_i), .adc_q(adc_q), .iq_valid(vld[1]), .iq_ready(iq_ready),
    .iq_i(oi[1]), .iq_q(oq[1]), .fill(fl[1]), .overrun(ovr[1]), .ovr_clr(ovr_clr));

  typedef struct {int i; int q;} samp_t;
  samp_t exp0[$];
  samp_t exp1[$];
  samp_t obs0[$];
  int  m_fill[2];
  int  m_phase[2];
  bit  m_ready[2];
  bit  m_ovr[2];
  int  n_tests = 0;
  int  n_fail = 0;

  function automatic void check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fill[k] = 0; m_phase[k] = 0; m_ready[k] = 0; m_ovr[k] = 0;
    end
    exp0.delete();
    exp1.delete();
  endfunction

  // Behavioural model of one clock edge, using the inputs present at that edge.
  function automatic void model_edge();
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int decim; bit acc, push, pop, drop; samp_t s;
      decim = (k == 0) ? 2 : 1;
      acc   = valid_adc && m_ready[k];
      drop  = valid_adc && !m_ready[k];
      push  = acc && (m_phase[k] == 0);
      pop   = (m_fill[k] != 0) && iq_ready;
      if (acc) m_phase[k] = (m_phase[k] + 1) % decim;
      if (push) begin
        s.i = int'(adc_i) - 512;
        s.q = int'(adc_q) - 512;
        if (k == 0) exp0.push_back(s); else exp1.push_back(s);
      end
      m_fill[k]  = m_fill[k] + int'(push) - int'(pop);
      m_ready[k] = (m_fill[k] < DEPTH);
      if (drop) m_ovr[k] = 1'b1;
      else if (ovr_clr) m_ovr[k] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input bit v, input bit r, input bit clr,
                               input logic [DW-1:0] i, input logic [DW-1:0] q);
    valid_adc = v; iq_ready = r; ovr_clr = clr; adc_i = i; adc_q = q;
    tick();
  endtask

  task automatic checkOutput(input int k);
    string tag;
    samp_t s;
    int    qsize;
    tag   = (k == 0) ? "dec2" : "dec1";
    qsize = (k == 0) ? exp0.size() : exp1.size();
    check({tag, ".ready"},   int'(rdy[k]), int'(m_ready[k]));
    check({tag, ".fill"},    int'(fl[k]),  m_fill[k]);
    check({tag, ".valid"},   int'(vld[k]), int'(m_fill[k] != 0));
    check({tag, ".overrun"}, int'(ovr[k]), int'(m_ovr[k]));
    if (vld[k]) begin
      if (qsize == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL %s.unexpected_valid: actual valid 1 required no sample pending", tag);
      end else begin
        s = (k == 0) ? exp0[0] : exp1[0];
        check({tag, ".iq_i"}, int'($signed(oi[k])), s.i);
        check({tag, ".iq_q"}, int'($signed(oq[k])), s.q);
        if (iq_ready) begin
          if (k == 0) begin
            void'(exp0.pop_front());
            obs0.push_back(s);
          end else begin
            void'(exp1.pop_front());
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  task automatic drain();
    int cyc = 0;
    while ((m_fill[0] != 0 || m_fill[1] != 0) && cyc < 40) begin
      applyStimulus(1'b0, 1'b1, 1'b1, '0, '0);
      cyc++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    check("drain.fill_dec2", int'(fl[0]), 0);
    check("drain.fill_dec1", int'(fl[1]), 0);
    check("drain.valid_dec2", int'(vld[0]), 0);
  endtask

  task automatic fillDec2();
    int cnt = 0;
    while (m_ready[0] && cnt < 40) begin
      applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
      cnt++;
    end
    valid_adc = 1'b0;
  endtask

  logic [DW-1:0] t2i [4];
  logic [DW-1:0] t2q [4];
  logic [DW-1:0] first_i, first_q;

  initial begin
    t2i = '{10'h200, 10'h123, 10'h000, 10'h3FF};
    t2q = '{10'h1FF, 10'h000, 10'h3FF, 10'h200};
    model_reset();

    // Reset held for three cycles: every output must read 0.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("t1.ready", int'(rdy[k]), 0);
        check("t1.valid", int'(vld[k]), 0);
        check("t1.fill", int'(fl[k]), 0);
        check("t1.overrun", int'(ovr[k]), 0);
        check("t1.iq_i", int'(oi[k]), 0);
        check("t1.iq_q", int'(oq[k]), 0);
      end
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    check("t1.ready_after_release", int'(rdy), 3);

    // Conversion and decimation with a free-running consumer.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, t2i[n], t2q[n]);
      if (n == 0) begin
        check("t2.latency_valid", int'(vld[0]), 1);
        check("t2.s0_i", int'($signed(oi[0])), 0);
        check("t2.s0_q", int'($signed(oq[0])), -1);
      end
      if (n == 2) begin
        check("t2.s2_i", int'($signed(oi[0])), -512);
        check("t2.s2_q", int'($signed(oq[0])), 511);
      end
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    check("t2.out_count", obs0.size(), 2);
    if (obs0.size() == 2) begin
      check("t2.out1_i", obs0[1].i, -512);
      check("t2.out1_q", obs0[1].q, 511);
    end

    // Fill with a stalled consumer, then drain in order.
    fillDec2();
    check("t3.fill_full", int'(fl[0]), 8);
    check("t3.ready_low", int'(rdy[0]), 0);
    check("t3.no_overrun", int'(ovr[0]), 0);
    drain();

    // Overrun: drops at full set it, clear works, a simultaneous drop wins.
    fillDec2();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    check("t4.overrun_set", int'(ovr[0]), 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    check("t4.overrun_sticky", int'(ovr[0]), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check("t4.overrun_cleared", int'(ovr[0]), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, DW'($urandom), DW'($urandom));
    check("t4.set_beats_clear", int'(ovr[0]), 1);
    drain();

    // Simultaneous push and pop at fill 4 on the undecimated instance.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    check("t5.fill_start", int'(fl[1]), 4);
    repeat (10) begin
      applyStimulus(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
      check("t5.fill_steady", int'(fl[1]), 4);
      check("t5.no_gap", int'(vld[1]), 1);
    end
    drain();

    // Asynchronous reset with data in flight.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    check("t6.fill_before", int'(fl[1]), 5);
    valid_adc = 1'b0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("t6.fill_async", int'(fl), 0);
    check("t6.valid_async", int'(vld), 0);
    check("t6.overrun_async", int'(ovr), 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    obs0.delete();
    first_i = DW'($urandom);
    first_q = DW'($urandom);
    applyStimulus(1'b1, 1'b1, 1'b0, first_i, first_q);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    check("t6.out_after_reset", int'(obs0.size() >= 1), 1);
    if (obs0.size() >= 1) begin
      check("t6.first_i", obs0[0].i, int'(first_i) - 512);
      check("t6.first_q", obs0[0].q, int'(first_q) - 512);
    end

    // Random traffic: bursty source, random back-pressure, occasional clears.
    repeat (400) begin
      applyStimulus(($urandom_range(99) < 70), ($urandom_range(99) < 55),
                    ($urandom_range(99) < 5), DW'($urandom), DW'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
